// File: rtl/lsu_bri_pkg.sv
// Shared types and sizes for the LSU-to-memory bus bridge.
package lsu_bri_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } bri_state_e;

  localparam int unsigned BRI_DW    = 64;
  localparam int unsigned BRI_NB    = BRI_DW / 8;
  localparam int unsigned BRI_OW    = $clog2(BRI_NB);
  localparam int unsigned BRI_TO_CW = 8;

endpackage

// File: rtl/lsu_bri_align.sv
// Byte-lane alignment: shifts store data/mask up to the bus lanes (with
// overflow detect) and shifts load data down to the LSU.
module lsu_bri_align #(
  parameter int DATA_WIDTH = 64,
  parameter int NB         = DATA_WIDTH / 8,
  parameter int OW         = $clog2(NB)
) (
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [NB-1:0]         mask_i,
  input  logic [OW-1:0]         wr_off_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [OW-1:0]         rd_off_i,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [NB-1:0]         mask_o,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Double-width mask so bits pushed past the top lane stay visible.
  logic [2*NB-1:0] mask_ext_s;

  assign mask_ext_s = {{NB{1'b0}}, mask_i} << wr_off_i;
  assign mask_o     = mask_ext_s[NB-1:0];
  assign misalign_o = |mask_ext_s[2*NB-1:NB];
  assign wdata_o    = wdata_i << {wr_off_i, 3'b000};
  assign rdata_o    = rdata_i >> {rd_off_i, 3'b000};

endmodule

// File: rtl/lsu_mem_bridge.sv
// Converts LSU single-cycle RAM strobes into one valid/ready bus transaction
// with lane alignment, misalign/timeout error reporting and a done pulse.
module lsu_mem_bridge
  import lsu_bri_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_lsu_ram_rd_en,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_ram_rd_addr,
  input  logic                    i_lsu_ram_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_ram_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_lsu_ram_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_lsu_ram_wr_mask,
  output logic [DATA_WIDTH-1:0]   o_bri_rd_data,
  output logic                    o_bri_done,
  output logic                    o_bri_err,
  output logic                    o_bri_busy,
  output logic                    o_bus_req_valid,
  input  logic                    i_bus_req_ready,
  output logic                    o_bus_req_we,
  output logic [ADDR_WIDTH-1:0]   o_bus_req_addr,
  output logic [DATA_WIDTH-1:0]   o_bus_req_wdata,
  output logic [DATA_WIDTH/8-1:0] o_bus_req_mask,
  input  logic                    i_bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   i_bus_rsp_rdata,
  output logic                    o_bus_rsp_ready
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam logic [BRI_TO_CW-1:0] TO_LAST = BRI_TO_CW'(TIMEOUT_CYCLES - 1);

  bri_state_e                state_q, state_d;
  logic                      we_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [OW-1:0]             off_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [NB-1:0]             mask_q;
  logic                      err_q;
  logic [BRI_TO_CW-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0]     rd_data_q;

  logic                      req_s;
  logic [ADDR_WIDTH-1:0]     sel_addr_s;
  logic [DATA_WIDTH-1:0]     wdata_sh_s;
  logic [NB-1:0]             mask_sh_s;
  logic                      misalign_s;
  logic [DATA_WIDTH-1:0]     rdata_sh_s;

  assign req_s      = i_lsu_ram_wr_en | i_lsu_ram_rd_en;
  assign sel_addr_s = i_lsu_ram_wr_en ? i_lsu_ram_wr_addr : i_lsu_ram_rd_addr;

  lsu_bri_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .wdata_i    (i_lsu_ram_wr_data),
    .mask_i     (i_lsu_ram_wr_mask),
    .wr_off_i   (sel_addr_s[OW-1:0]),
    .rdata_i    (i_bus_rsp_rdata),
    .rd_off_i   (off_q),
    .wdata_o    (wdata_sh_s),
    .mask_o     (mask_sh_s),
    .misalign_o (misalign_s),
    .rdata_o    (rdata_sh_s)
  );

  // Next-state logic; a misaligned store skips the bus entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = (i_lsu_ram_wr_en && misalign_s) ? DONE : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (i_bus_req_ready) begin
          state_d = RSP;
        end else begin
          state_d = REQ;
        end
      end
      RSP: begin
        if (i_bus_rsp_valid || (cnt_q == TO_LAST)) begin
          state_d = DONE;
        end else begin
          state_d = RSP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request latches, timeout counter and load-data register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_s) begin
            we_q    <= i_lsu_ram_wr_en;
            addr_q  <= {sel_addr_s[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            off_q   <= sel_addr_s[OW-1:0];
            wdata_q <= i_lsu_ram_wr_en ? wdata_sh_s : '0;
            mask_q  <= i_lsu_ram_wr_en ? mask_sh_s : '1;
            err_q   <= i_lsu_ram_wr_en & misalign_s;
            cnt_q   <= '0;
          end
        end
        RSP: begin
          cnt_q <= cnt_q + {{(BRI_TO_CW-1){1'b0}}, 1'b1};
          if (i_bus_rsp_valid) begin
            if (!we_q) begin
              rd_data_q <= rdata_sh_s;
            end
          end else if (cnt_q == TO_LAST) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  assign o_bri_rd_data   = rd_data_q;
  assign o_bri_done      = (state_q == DONE);
  assign o_bri_err       = (state_q == DONE) & err_q;
  assign o_bri_busy      = (state_q != IDLE);
  assign o_bus_req_valid = (state_q == REQ);
  assign o_bus_rsp_ready = (state_q == RSP);
  assign o_bus_req_we    = we_q;
  assign o_bus_req_addr  = addr_q;
  assign o_bus_req_wdata = wdata_q;
  assign o_bus_req_mask  = mask_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Scoreboard bench for lsu_mem_bridge: expectations are queued when an access
// is issued and compared when the bridge reports done.
module tb_lsu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en, wr_en;
  logic [31:0] rd_addr, wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic [63:0] bri_rd_data;
  logic        bri_done, bri_err, bri_busy;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_mask;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;

  typedef struct {
    logic        err;
    logic [63:0] rd;
    logic        we;
    logic [31:0] baddr;
    logic [63:0] bwdata;
    logic [7:0]  bmask;
    logic        has_req;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] rd_model = 64'd0;

  always #5 clk = ~clk;

  lsu_mem_bridge dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_lsu_ram_rd_en   (rd_en),
    .i_lsu_ram_rd_addr (rd_addr),
    .i_lsu_ram_wr_en   (wr_en),
    .i_lsu_ram_wr_addr (wr_addr),
    .i_lsu_ram_wr_data (wr_data),
    .i_lsu_ram_wr_mask (wr_mask),
    .o_bri_rd_data     (bri_rd_data),
    .o_bri_done        (bri_done),
    .o_bri_err         (bri_err),
    .o_bri_busy        (bri_busy),
    .o_bus_req_valid   (req_valid),
    .i_bus_req_ready   (req_ready),
    .o_bus_req_we      (req_we),
    .o_bus_req_addr    (req_addr),
    .o_bus_req_wdata   (req_wdata),
    .o_bus_req_mask    (req_mask),
    .i_bus_rsp_valid   (rsp_valid),
    .i_bus_rsp_rdata   (rsp_rdata),
    .o_bus_rsp_ready   (rsp_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"},  bri_busy,  0);
    check_eq({tag, "_done"},  bri_done,  0);
    check_eq({tag, "_err"},   bri_err,   0);
    check_eq({tag, "_rqv"},   req_valid, 0);
    check_eq({tag, "_rsr"},   rsp_ready, 0);
  endtask

  // One LSU access; bus answers after rdy_wait / rsp_wait cycles (rsp_wait>=255 never answers).
  task automatic access(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [7:0] mask, input int rdy_wait, input int rsp_wait,
                        input logic [63:0] rdata, input string tag);
    exp_t        e;
    logic [15:0] m16;
    int          off;
    bit          got_done, seen_req;
    int          cyc, rdy_cnt, rsp_cnt;
    off      = int'(addr[2:0]);
    m16      = {8'd0, mask} << off;
    e.we     = we;
    e.baddr  = {addr[31:3], 3'b000};
    e.bwdata = wdata << (off * 8);
    e.bmask  = we ? m16[7:0] : 8'hFF;
    e.has_req = !(we && (m16[15:8] != 8'd0));
    if (!e.has_req) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (rsp_wait >= 255) begin
      e.err = 1'b1;
      e.lat = 2 + rdy_wait + 255;
    end else begin
      e.err = 1'b0;
      e.lat = 3 + rdy_wait + rsp_wait;
      if (!we) rd_model = rdata >> (off * 8);
    end
    e.rd = rd_model;
    sb_q.push_back(e);

    rd_en   = 1'b1;
    wr_en   = we;
    rd_addr = addr;
    wr_addr = addr;
    wr_data = wdata;
    wr_mask = mask;
    got_done = 0; seen_req = 0; cyc = 0; rdy_cnt = 0; rsp_cnt = 0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      step();
      cyc++;
      if (bri_done) begin
        got_done = 1;
        check_eq({tag, "_sb_size"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq({tag, "_lat"},    cyc,         e.lat);
          check_eq({tag, "_err"},    bri_err,     e.err);
          check_eq({tag, "_rdata"},  bri_rd_data, e.rd);
          check_eq({tag, "_hasreq"}, seen_req,    e.has_req);
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
      end
      if (req_valid) begin
        seen_req = 1;
        check_eq({tag, "_baddr"}, req_addr,  e.baddr);
        check_eq({tag, "_bwe"},   req_we,    e.we);
        check_eq({tag, "_bmask"}, req_mask,  e.bmask);
        if (we) check_eq({tag, "_bwdata"}, req_wdata, e.bwdata);
        req_ready = (rdy_cnt == rdy_wait);
        rdy_cnt++;
      end else begin
        req_ready = 1'b0;
      end
      if (rsp_ready) begin
        rsp_valid = (rsp_cnt == rsp_wait);
        rsp_rdata = (rsp_cnt == rsp_wait) ? rdata : 64'hDEAD_BEEF_DEAD_BEEF;
        rsp_cnt++;
      end else begin
        rsp_valid = 1'b0;
      end
    end
    check_eq({tag, "_done_seen"}, got_done, 1);
    step();
    check_eq({tag, "_done_pulse"}, bri_done, 0);
    check_eq({tag, "_idle"},       bri_busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; rd_addr = '0; wr_addr = '0;
    wr_data = '0; wr_mask = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    step(); step();
    check_quiet("rst");
    check_eq("rst_rdata", bri_rd_data, 64'd0);
    check_eq("rst_addr",  req_addr,    64'd0);
    check_eq("rst_mask",  req_mask,    64'd0);
    rst_n = 1'b1;
    step();

    access(1'b0, 32'h8000_0010, 64'd0, 8'h00, 0, 0, 64'h1122_3344_5566_7788, "ld_align");
    check_eq("ld_align_lit", bri_rd_data, 64'h1122_3344_5566_7788);
    access(1'b0, 32'h8000_0006, 64'd0, 8'h00, 0, 0, 64'h1122_3344_5566_7788, "ld_off6");
    check_eq("ld_off6_lit", bri_rd_data, 64'h0000_0000_0000_1122);
    access(1'b1, 32'h8000_0005, 64'hAB, 8'h01, 0, 0, 64'd0, "st_off5");
    check_eq("st_off5_keep", bri_rd_data, 64'h0000_0000_0000_1122);
    access(1'b1, 32'h8000_0006, 64'hFFFF_FFFF, 8'h0F, 0, 0, 64'd0, "st_mis");
    access(1'b1, 32'h8000_0006, 64'hBEEF, 8'h03, 0, 0, 64'd0, "st_edge");
    access(1'b1, 32'h8000_0020, 64'h0102_0304_0506_0708, 8'hFF, 5, 0, 64'd0, "st_bp5");
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 32'h8000_0100 + 32'(i * 3), 64'd0, 8'h00, i, 3 - i,
             {$urandom, $urandom}, "ld_rand");
    end
    access(1'b0, 32'h8000_0040, 64'd0, 8'h00, 1, 1000, 64'h5555_AAAA_5555_AAAA, "ld_tmo");
    access(1'b0, 32'h8000_0041, 64'd0, 8'h00, 0, 2, 64'hCAFE_F00D_1234_5678, "ld_after");

    // Reset while waiting in RSP, then a stray response must be ignored.
    rd_en = 1'b1; rd_addr = 32'h8000_0008;
    step(); step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rd_en = 1'b0;
    check_eq("mid_rsp_state", rsp_ready, 1);
    rst_n = 1'b0;
    step();
    check_quiet("mid_rst");
    check_eq("mid_rst_rdata", bri_rd_data, 64'd0);
    check_eq("mid_rst_we",    req_we,      64'd0);
    rst_n = 1'b1;
    rsp_valid = 1'b1; rsp_rdata = 64'h9999_8888_7777_6666;
    step(); step(); step();
    rsp_valid = 1'b0;
    check_quiet("stray");
    check_eq("stray_rdata", bri_rd_data, 64'd0);
    check_eq("sb_final", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
